// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite responder in front of a word-organised on-chip SRAM. It captures the
//   address phase and runs the data phase with WAIT_STATES wait cycles. It commits
//   byte, half and word writes, and it returns full-word reads. An illegal access
//   (bad size, misaligned or out of range) gets a two-cycle ERROR response and never
//   touches the SRAM.
// Ports
//   clk        bus clock, rising edge
//   reset_n    async active-low reset
//   hsel       slave select
//   haddr      byte address (address phase)
//   htrans     transfer type; only NONSEQ/SEQ start a transfer
//   hwrite     1 = write
//   hsize      000 byte, 001 half, 010 word
//   hwdata     write data (data phase)
//   hready     bus ready; an address phase counts only when high
//   hrdata     read data; SRAM word while in DATA, else 0
//   hreadyout  slave ready; low extends the data phase
//   hresp      0 OKAY, 1 ERROR
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  // The counter is loaded with WAIT_STATES-1. DATA follows the cycle that sees 0.
  localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [2:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_be;
  logic          r_write;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_illegal;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic          w_unused;

  assign w_unused = htrans[0];

  // Only NONSEQ/SEQ (htrans[1]) start a transfer. IDLE and BUSY fall through to IDLE.
  assign w_accept   = hsel & hready & htrans[1];
  assign w_misalign = ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign w_illegal  = (hsize > 3'b010) || w_misalign || (haddr >= 32'(DEPTH * 4));

  // Byte enables are decoded in the address phase, so the write only has to apply them.
  always_comb begin
    w_be = 4'b1111;
    case (hsize)
      3'b000:  w_be = 4'b0001 << haddr[1:0];
      3'b001:  w_be = haddr[1] ? 4'b1100 : 4'b0011;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_be    <= 4'd0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_DATA;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ERR1: r_state <= S_ERR2;
        default: begin
          // IDLE, DATA and ERR2 are the ready cycles. A new address phase here
          // pipelines straight into the next transfer with no bubble.
          if (w_accept) begin
            r_idx   <= haddr[AW+1:2];
            r_be    <= w_be;
            r_write <= hwrite;
            if (w_illegal) begin
              r_state <= S_ERR1;
            end else if (WAIT_STATES == 0) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WS_M1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // The write commits on the edge that ends DATA. An async reset forces r_state out of
  // DATA at once, so a write still in flight is dropped. The SRAM itself is never reset.
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata    = (r_state == S_DATA) ? r_mem[r_idx] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave. Two instances run side by side, one with WAIT_STATES=0
// and one with WAIT_STATES=3. Each has its own bus, and hready is tied to its own
// hreadyout. A transfer-level model predicts, for every cycle, hreadyout, hresp and
// hrdata from the phase of the transfer in flight. It keeps an associative SRAM image.
module tb_ahb_sram_slave;
  localparam int DEPTH = 64;
  localparam int NCYC  = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit done [2];

  // kind: 0 IDLE, 1 BUSY, 2 hsel=0 (NONSEQ on bus), 3 NONSEQ, 4 SEQ
  typedef struct {
    int          kind;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    bit          rst;
  } item_t;

  typedef struct {
    bit          act;
    bit          ill;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    int          cnt;
    bit          rst;
  } ph_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if (a % (32'd1 << s) != 0) return 1'b0;
    return a < 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] s);
    logic [31:0] r;
    int lane;
    r = old;
    if (s == 3'd0) begin
      lane = int'(a % 4);
      r[8*lane +: 8] = wd[8*lane +: 8];
    end else if (s == 3'd1) begin
      lane = int'((a % 4) / 2);
      r[16*lane +: 16] = wd[16*lane +: 16];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  function automatic item_t mk(input int k, input bit wr, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] wd, input bit rst);
    item_t it;
    it.kind = k; it.wr = wr; it.addr = a; it.size = s; it.wd = wd; it.rst = rst;
    return it;
  endfunction

  function automatic item_t rnd_item();
    int          k;
    int          w;
    logic [2:0]  s;
    logic [31:0] a;
    k = int'($urandom_range(0, 9));
    if (k < 3) return mk(k, 1'($urandom), $urandom, 3'($urandom), $urandom, 1'b0);
    s = ($urandom_range(0, 14) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    w = ($urandom_range(0, 16) == 16) ? DEPTH - 1 : int'($urandom_range(0, 15));
    a = 32'(w * 4);
    if ($urandom_range(0, 5) == 0)       a = a + $urandom_range(1, 3);
    else if (s == 3'd0)                  a = a + $urandom_range(0, 3);
    else if (s == 3'd1)                  a = a + 2 * $urandom_range(0, 1);
    if ($urandom_range(0, 14) == 0)      a = 32'(DEPTH * 4) + 4 * $urandom_range(0, 3);
    return mk(($urandom_range(0, 1) == 1) ? 4 : 3, 1'($urandom), a, s, $urandom, 1'b0);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 0 : 3;

    logic        reset_n, hsel, hwrite, hready, hreadyout, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    assign hready = hreadyout;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .reset_n(reset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
    );

    task automatic drive(input item_t it);
      hsel   = (it.kind != 2);
      htrans = (it.kind == 0) ? 2'b00 : (it.kind == 1) ? 2'b01 :
               (it.kind == 4) ? 2'b11 : 2'b10;
      haddr  = it.addr;
      hwrite = it.wr;
      hsize  = it.size;
    endtask

    initial begin
      item_t       dq [$];
      item_t       cur;
      item_t       idle;
      ph_t         ph;
      logic [31:0] mem [int];
      bit          er, ep, known;
      logic [31:0] ed;
      int          w;
      string       p;

      p    = $sformatf("ws%0d", WS);
      idle = mk(0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0);
      ph   = '{act: 1'b0, ill: 1'b0, wr: 1'b0, addr: 32'd0, size: 3'd0, wd: 32'd0,
               cnt: 0, rst: 1'b0};
      reset_n = 1'b0;
      hwdata  = 32'd0;
      drive(idle);
      repeat (2) @(negedge clk);
      chk({p, " reset hreadyout"}, 32'(hreadyout), 32'd1);
      chk({p, " reset hresp"},     32'(hresp),     32'd0);
      chk({p, " reset hrdata"},    hrdata,         32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) dq.push_back(mk(3, 1'b1, 32'(i * 4), 3'd2, $urandom, 1'b0));
      dq.push_back(mk(3, 1'b1, 32'((DEPTH - 1) * 4), 3'd2, $urandom, 1'b0));
      dq.push_back(mk(3, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
      dq.push_back(mk(3, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(3, 1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0));
      dq.push_back(mk(4, 1'b1, 32'h13, 3'd0, 32'hAB000000, 1'b0));
      dq.push_back(mk(4, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(3, 1'b1, 32'h12, 3'd1, 32'h55660000, 1'b0));
      dq.push_back(idle);
      dq.push_back(mk(3, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(3, 1'b0, 32'(DEPTH * 4), 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(1, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(3, 1'b0, 32'h10, 3'd3, 32'd0, 1'b0));
      dq.push_back(mk(3, 1'b1, 32'h2, 3'd2, 32'hFFFFFFFF, 1'b0));
      dq.push_back(mk(3, 1'b0, 32'h0, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(2, 1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 1'b0));
      dq.push_back(mk(3, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      dq.push_back(mk(4, 1'b0, 32'h14, 3'd2, 32'd0, 1'b0));
      if (WS >= 2) begin
        dq.push_back(mk(3, 1'b1, 32'h10, 3'd2, 32'h0BADF00D, 1'b1));
        dq.push_back(mk(3, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0));
      end

      cur = idle;
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk);
        known = 1'b1;
        ed    = 32'd0;
        if (!ph.act) begin
          er = 1'b1; ep = 1'b0;
        end else if (ph.ill) begin
          er = (ph.cnt == 1); ep = 1'b1;
        end else begin
          er = (ph.cnt == WS); ep = 1'b0;
          if (er) begin
            w = int'(ph.addr / 4);
            if (mem.exists(w)) ed = mem[w];
            else               known = 1'b0;
          end
        end
        chk({p, " hreadyout"}, 32'(hreadyout), 32'(er));
        chk({p, " hresp"},     32'(hresp),     32'(ep));
        if (known) chk({p, " hrdata"}, hrdata, ed);

        if (ph.act && ph.rst && ph.cnt == 1) begin
          reset_n = 1'b0;
          #1;
          chk({p, " midrst hreadyout"}, 32'(hreadyout), 32'd1);
          chk({p, " midrst hresp"},     32'(hresp),     32'd0);
          chk({p, " midrst hrdata"},    hrdata,         32'd0);
          ph.act = 1'b0;
          cur    = idle;
          drive(idle);
          @(negedge clk);
          reset_n = 1'b1;
          continue;
        end

        hwdata = (ph.act && ph.wr) ? ph.wd : $urandom;
        if (er) begin
          if (dq.size() > 0)   cur = dq.pop_front();
          else if (c < NCYC - 20) cur = rnd_item();
          else                 cur = idle;
          drive(cur);
        end

        @(posedge clk);
        if (ph.act) begin
          if (er) begin
            if (!ph.ill && ph.wr) begin
              w = int'(ph.addr / 4);
              if (mem.exists(w))       mem[w] = merge(mem[w], ph.wd, ph.addr, ph.size);
              else if (ph.size == 3'd2) mem[w] = ph.wd;
            end
            ph.act = 1'b0;
          end else begin
            ph.cnt++;
          end
        end
        if (er && cur.kind >= 3) begin
          ph.act  = 1'b1;
          ph.ill  = !legal(cur.addr, cur.size);
          ph.wr   = cur.wr;
          ph.addr = cur.addr;
          ph.size = cur.size;
          ph.wd   = cur.wd;
          ph.cnt  = 0;
          ph.rst  = cur.rst;
        end
      end
      done[gi] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
